scratchpad_port_arbiter: RTL and testbench

//  Shares one single-port 4096x32 on-chip scratchpad between two Avalon-MM masters:
//  m0 = Nios core data port, m1 = fingerprint/DMA engine.

---
 rtl/scratchpad_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 57 +++++
 rtl/scratchpad_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_scratchpad_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scratchpad_pkg.sv
// ---------------------------------------------------------------------------
// scratchpad_pkg
// Purpose : Shared definitions for the scratchpad port arbiter slice.
//           Holds the default geometry of the 4096x32 scratchpad, the
//           byteenable width derivation and the grant encoding used by both
//           the arbiter sub-module and the read-return tracker.
// Contents: ADDR_W_DEFAULT, DATA_W_DEFAULT, CNT_W_DEFAULT, grant_e
//           (GNT_M0 / GNT_M1), be_width().
// ---------------------------------------------------------------------------
package scratchpad_pkg;

    localparam int ADDR_W_DEFAULT = 12;
    localparam int DATA_W_DEFAULT = 32;
    localparam int CNT_W_DEFAULT  = 16;

    // Which master owns a grant (or an outstanding read).
    typedef enum logic {
        GNT_M0 = 1'b0,
        GNT_M1 = 1'b1
    } grant_e;

    // One byteenable lane per byte of data.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Purpose : Two-way per-cycle arbiter. Grants are combinational. A single
//           requester always wins. On contention the winner is m0 when
//           FIXED_PRI is set, otherwise whichever master did not win last.
// Ports   : clk, reset_n (sync, active-low)
//           enable      - 0 suppresses all grants (reset / reset_req)
//           req0, req1  - request from master 0 / 1
//           gnt0, gnt1  - one-hot-or-zero grant
// ---------------------------------------------------------------------------
module rr_arb2
    import scratchpad_pkg::*;
#(
    parameter int FIXED_PRI = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    grant_e last_grant;

    // Grant decision for this cycle. On contention, a last_grant of m1 (the
    // reset value) hands the win to m0, so m0 takes the first contention.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (enable) begin
            if (req0 && req1) begin
                if ((FIXED_PRI != 0) || (last_grant == GNT_M1)) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Remember the most recent winner. Idle cycles leave the history alone.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= GNT_M1;
        end else if (gnt0) begin
            last_grant <= GNT_M0;
        end else if (gnt1) begin
            last_grant <= GNT_M1;
        end
    end

endmodule

// File: rtl/scratchpad_port_arbiter.sv
// ---------------------------------------------------------------------------
// scratchpad_port_arbiter
// Purpose : Shares one single-port scratchpad RAM between two Avalon-MM
//           masters (m0 = Nios data port, m1 = fingerprint/DMA engine).
//           Arbitrates per access, muxes the winner onto the RAM and returns
//           read data with a fixed one-cycle readdatavalid to its owner.
// Ports   : clk, reset_n (sync, active-low), reset_req (freezes the RAM)
//           mN_address/read/write/byteenable/writedata   - master requests
//           mN_waitrequest/readdata/readdatavalid         - master responses
//           ram_address/byteenable/chipselect/write/writedata/clken - to RAM
//           ram_readdata                                  - unregistered RAM q
//           stall_cnt0/1 - saturating count of cycles each master lost
// ---------------------------------------------------------------------------
module scratchpad_port_arbiter
    import scratchpad_pkg::*;
#(
    parameter  int ADDR_W    = ADDR_W_DEFAULT,
    parameter  int DATA_W    = DATA_W_DEFAULT,
    parameter  int FIXED_PRI = 0,
    parameter  int CNT_W     = CNT_W_DEFAULT,
    localparam int BE_W      = be_width(DATA_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reset_req,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata,

    output logic [CNT_W-1:0]  stall_cnt0,
    output logic [CNT_W-1:0]  stall_cnt1
);

    logic   req0;
    logic   req1;
    logic   gnt0;
    logic   gnt1;
    logic   arb_enable;
    logic   rd_accept;
    logic   rd_pend;
    grant_e rd_owner;

    // A simultaneous read+write is treated as a write, so either strobe counts
    // as a request, but only a pure read produces a read response.
    assign req0       = m0_read | m0_write;
    assign req1       = m1_read | m1_write;
    assign arb_enable = reset_n & ~reset_req;

    rr_arb2 #(
        .FIXED_PRI (FIXED_PRI)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (arb_enable),
        .req0    (req0),
        .req1    (req1),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );

    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;
    assign ram_clken      = ~reset_req;

    // RAM-side mux. m0 drives the address/data lines unless m1 holds the
    // grant; with no grant the lines are don't-care and chipselect is low.
    always_comb begin
        ram_address    = m0_address;
        ram_byteenable = m0_byteenable;
        ram_writedata  = m0_writedata;
        if (gnt1) begin
            ram_address    = m1_address;
            ram_byteenable = m1_byteenable;
            ram_writedata  = m1_writedata;
        end
        ram_chipselect = gnt0 | gnt1;
        ram_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
    end

    assign rd_accept = (gnt0 & m0_read & ~m0_write) |
                       (gnt1 & m1_read & ~m1_write);

    // Read-return tracker. The RAM q is valid one cycle after issue, so a
    // single pending flag plus owner is enough to sustain one read per cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= GNT_M0;
        end else begin
            rd_pend <= rd_accept;
            if (rd_accept) begin
                rd_owner <= gnt1 ? GNT_M1 : GNT_M0;
            end
        end
    end

    // Gating with reset_n drops a response whose cycle coincides with reset.
    assign m0_readdatavalid = reset_n & rd_pend & (rd_owner == GNT_M0);
    assign m1_readdatavalid = reset_n & rd_pend & (rd_owner == GNT_M1);
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;

    // Stall counters. A master stalls only when it requests while the other
    // master holds the grant; reset_req cycles grant nobody, so they hold.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt0 <= '0;
            stall_cnt1 <= '0;
        end else begin
            if (req0 && gnt1 && (stall_cnt0 != {CNT_W{1'b1}})) begin
                stall_cnt0 <= stall_cnt0 + CNT_W'(1);
            end
            if (req1 && gnt0 && (stall_cnt1 != {CNT_W{1'b1}})) begin
                stall_cnt1 <= stall_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_scratchpad_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_scratchpad_port_arbiter
// Purpose : Self-checking bench for scratchpad_port_arbiter. A round-robin
//           instance is checked against a table of per-cycle vectors; a
//           second, fixed-priority instance shares the same stimulus and is
//           checked in its own sequence. Each instance has a small RAM model
//           with a registered read address, like the real scratchpad.
// ---------------------------------------------------------------------------
module tb_scratchpad_port_arbiter;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    typedef struct {
        logic        r0;
        logic        w0;
        logic [11:0] a0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic        r1;
        logic        w1;
        logic [11:0] a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic        rq;
    } in_t;

    typedef struct {
        logic        wait0;
        logic        wait1;
        logic        rdv0;
        logic        rdv1;
        logic        cs;
        logic        we;
        logic        clken;
        logic [11:0] addr;
        logic [31:0] rdata;
        logic [15:0] st0;
        logic [15:0] st1;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    localparam in_t IDLE = '{N, N, 12'h0, 4'h0, 32'h0, N, N, 12'h0, 4'h0, 32'h0, N};

    logic        clk;
    logic        reset_n;
    logic        reset_req;
    logic        init_mem;
    logic [11:0] m0_address;
    logic        m0_read;
    logic        m0_write;
    logic [3:0]  m0_byteenable;
    logic [31:0] m0_writedata;
    logic [11:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [3:0]  m1_byteenable;
    logic [31:0] m1_writedata;

    logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata, ram_writedata, ram_readdata;
    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [15:0] stall_cnt0, stall_cnt1;

    logic        m0_waitrequest_f, m0_readdatavalid_f, m1_waitrequest_f, m1_readdatavalid_f;
    logic [31:0] m0_readdata_f, m1_readdata_f, ram_writedata_f, ram_readdata_f;
    logic [11:0] ram_address_f;
    logic [3:0]  ram_byteenable_f;
    logic        ram_chipselect_f, ram_write_f, ram_clken_f;
    logic [15:0] stall_cnt0_f, stall_cnt1_f;

    logic [31:0] mem   [0:4095];
    logic [31:0] mem_f [0:4095];
    logic [11:0] q_addr;
    logic [11:0] q_addr_f;

    int   checks;
    int   errors;
    vec_t tbl [18];

    scratchpad_port_arbiter #(.FIXED_PRI(0)) dut (
        .clk (clk), .reset_n (reset_n), .reset_req (reset_req),
        .m0_address (m0_address), .m0_read (m0_read), .m0_write (m0_write),
        .m0_byteenable (m0_byteenable), .m0_writedata (m0_writedata),
        .m0_waitrequest (m0_waitrequest), .m0_readdata (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address (m1_address), .m1_read (m1_read), .m1_write (m1_write),
        .m1_byteenable (m1_byteenable), .m1_writedata (m1_writedata),
        .m1_waitrequest (m1_waitrequest), .m1_readdata (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .ram_address (ram_address), .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect), .ram_write (ram_write),
        .ram_writedata (ram_writedata), .ram_clken (ram_clken),
        .ram_readdata (ram_readdata),
        .stall_cnt0 (stall_cnt0), .stall_cnt1 (stall_cnt1)
    );

    scratchpad_port_arbiter #(.FIXED_PRI(1)) dut_f (
        .clk (clk), .reset_n (reset_n), .reset_req (reset_req),
        .m0_address (m0_address), .m0_read (m0_read), .m0_write (m0_write),
        .m0_byteenable (m0_byteenable), .m0_writedata (m0_writedata),
        .m0_waitrequest (m0_waitrequest_f), .m0_readdata (m0_readdata_f),
        .m0_readdatavalid (m0_readdatavalid_f),
        .m1_address (m1_address), .m1_read (m1_read), .m1_write (m1_write),
        .m1_byteenable (m1_byteenable), .m1_writedata (m1_writedata),
        .m1_waitrequest (m1_waitrequest_f), .m1_readdata (m1_readdata_f),
        .m1_readdatavalid (m1_readdatavalid_f),
        .ram_address (ram_address_f), .ram_byteenable (ram_byteenable_f),
        .ram_chipselect (ram_chipselect_f), .ram_write (ram_write_f),
        .ram_writedata (ram_writedata_f), .ram_clken (ram_clken_f),
        .ram_readdata (ram_readdata_f),
        .stall_cnt0 (stall_cnt0_f), .stall_cnt1 (stall_cnt1_f)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model for the round-robin instance: byte-lane writes and a
    // registered read address, both frozen when clken is low. The preset
    // pattern 0x1000_0000 | index makes every word's read data distinct.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h1000_0000 | 32'(i);
        end else if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
                end
            end
            q_addr <= ram_address;
        end
    end
    assign ram_readdata = mem[q_addr];

    // Identical RAM model for the fixed-priority instance.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 4096; i++) mem_f[i] <= 32'h1000_0000 | 32'(i);
        end else if (ram_clken_f && ram_chipselect_f) begin
            if (ram_write_f) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable_f[b]) mem_f[ram_address_f][8*b +: 8] <= ram_writedata_f[8*b +: 8];
                end
            end
            q_addr_f <= ram_address_f;
        end
    end
    assign ram_readdata_f = mem_f[q_addr_f];

    // Drive one cycle of master-side inputs on the falling edge.
    task automatic applyStimulus(input in_t v);
        @(negedge clk);
        m0_read       = v.r0;
        m0_write      = v.w0;
        m0_address    = v.a0;
        m0_byteenable = v.be0;
        m0_writedata  = v.d0;
        m1_read       = v.r1;
        m1_write      = v.w1;
        m1_address    = v.a1;
        m1_byteenable = v.be1;
        m1_writedata  = v.d1;
        reset_req     = v.rq;
    endtask

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, table of vectors, then hand-written corner cases.
    initial begin
        int accepts;
        checks   = 0;
        errors   = 0;
        accepts  = 0;
        reset_n  = 1'b0;
        init_mem = 1'b1;
        applyStimulus(IDLE);

        // Contention from reset: m0, m1, m0, m1; responses land on the owner.
        tbl[0]  = '{'{Y, N, 12'h010, 4'h0, 32'h0, Y, N, 12'h020, 4'h0, 32'h0, N},
                    '{N, Y, N, N, Y, N, Y, 12'h010, 32'h0, 16'd0, 16'd0}};
        tbl[1]  = '{'{Y, N, 12'h011, 4'h0, 32'h0, Y, N, 12'h020, 4'h0, 32'h0, N},
                    '{Y, N, Y, N, Y, N, Y, 12'h020, 32'h1000_0010, 16'd0, 16'd1}};
        tbl[2]  = '{'{Y, N, 12'h011, 4'h0, 32'h0, Y, N, 12'h021, 4'h0, 32'h0, N},
                    '{N, Y, N, Y, Y, N, Y, 12'h011, 32'h1000_0020, 16'd1, 16'd1}};
        tbl[3]  = '{'{Y, N, 12'h012, 4'h0, 32'h0, Y, N, 12'h021, 4'h0, 32'h0, N},
                    '{Y, N, Y, N, Y, N, Y, 12'h021, 32'h1000_0011, 16'd1, 16'd2}};
        tbl[4]  = '{IDLE, '{Y, Y, N, Y, N, N, Y, 12'h000, 32'h1000_0021, 16'd2, 16'd2}};
        // m0 write then read-back of the same word.
        tbl[5]  = '{'{N, Y, 12'h0A5, 4'hF, 32'hDEAD_BEEF, N, N, 12'h0, 4'h0, 32'h0, N},
                    '{N, Y, N, N, Y, Y, Y, 12'h0A5, 32'h0, 16'd2, 16'd2}};
        tbl[6]  = '{'{Y, N, 12'h0A5, 4'h0, 32'h0, N, N, 12'h0, 4'h0, 32'h0, N},
                    '{N, Y, N, N, Y, N, Y, 12'h0A5, 32'h0, 16'd2, 16'd2}};
        tbl[7]  = '{IDLE, '{Y, Y, Y, N, N, N, Y, 12'h000, 32'hDEAD_BEEF, 16'd2, 16'd2}};
        // m1 partial write over an all-ones word.
        tbl[8]  = '{'{N, N, 12'h0, 4'h0, 32'h0, N, Y, 12'h123, 4'hF, 32'hFFFF_FFFF, N},
                    '{Y, N, N, N, Y, Y, Y, 12'h123, 32'h0, 16'd2, 16'd2}};
        tbl[9]  = '{'{N, N, 12'h0, 4'h0, 32'h0, N, Y, 12'h123, 4'h3, 32'h1111_2222, N},
                    '{Y, N, N, N, Y, Y, Y, 12'h123, 32'h0, 16'd2, 16'd2}};
        tbl[10] = '{'{N, N, 12'h0, 4'h0, 32'h0, Y, N, 12'h123, 4'h0, 32'h0, N},
                    '{Y, N, N, N, Y, N, Y, 12'h123, 32'h0, 16'd2, 16'd2}};
        tbl[11] = '{IDLE, '{Y, Y, N, Y, N, N, Y, 12'h000, 32'hFFFF_2222, 16'd2, 16'd2}};
        // m0 read, then reset_req for three cycles while m1 waits.
        tbl[12] = '{'{Y, N, 12'h0A5, 4'h0, 32'h0, N, N, 12'h0, 4'h0, 32'h0, N},
                    '{N, Y, N, N, Y, N, Y, 12'h0A5, 32'h0, 16'd2, 16'd2}};
        tbl[13] = '{'{N, N, 12'h0, 4'h0, 32'h0, Y, N, 12'h123, 4'h0, 32'h0, Y},
                    '{Y, Y, Y, N, N, N, N, 12'h000, 32'hDEAD_BEEF, 16'd2, 16'd2}};
        tbl[14] = '{'{N, N, 12'h0, 4'h0, 32'h0, Y, N, 12'h123, 4'h0, 32'h0, Y},
                    '{Y, Y, N, N, N, N, N, 12'h000, 32'h0, 16'd2, 16'd2}};
        tbl[15] = '{'{N, N, 12'h0, 4'h0, 32'h0, Y, N, 12'h123, 4'h0, 32'h0, Y},
                    '{Y, Y, N, N, N, N, N, 12'h000, 32'h0, 16'd2, 16'd2}};
        tbl[16] = '{'{N, N, 12'h0, 4'h0, 32'h0, Y, N, 12'h123, 4'h0, 32'h0, N},
                    '{Y, N, N, N, Y, N, Y, 12'h123, 32'h0, 16'd2, 16'd2}};
        tbl[17] = '{IDLE, '{Y, Y, N, Y, N, N, Y, 12'h000, 32'hFFFF_2222, 16'd2, 16'd2}};

        init_mem = 1'b0;
        applyStimulus(IDLE);
        #1;
        checkOutput("rst.wait0", 32'(m0_waitrequest), 32'd1);
        checkOutput("rst.wait1", 32'(m1_waitrequest), 32'd1);
        checkOutput("rst.rdv0", 32'(m0_readdatavalid), 32'd0);
        checkOutput("rst.rdv1", 32'(m1_readdatavalid), 32'd0);
        applyStimulus(IDLE);
        reset_n = 1'b1;
        #1;
        checkOutput("rst.st0", 32'(stall_cnt0), 32'd0);
        checkOutput("rst.st1", 32'(stall_cnt1), 32'd0);
        checkOutput("rst.chipselect", 32'(ram_chipselect), 32'd0);

        for (int k = 0; k < 18; k++) begin
            applyStimulus(tbl[k].i);
            #1;
            checkOutput($sformatf("v%0d.wait0", k), 32'(m0_waitrequest), 32'(tbl[k].e.wait0));
            checkOutput($sformatf("v%0d.wait1", k), 32'(m1_waitrequest), 32'(tbl[k].e.wait1));
            checkOutput($sformatf("v%0d.rdv0", k), 32'(m0_readdatavalid), 32'(tbl[k].e.rdv0));
            checkOutput($sformatf("v%0d.rdv1", k), 32'(m1_readdatavalid), 32'(tbl[k].e.rdv1));
            checkOutput($sformatf("v%0d.cs", k), 32'(ram_chipselect), 32'(tbl[k].e.cs));
            checkOutput($sformatf("v%0d.we", k), 32'(ram_write), 32'(tbl[k].e.we));
            checkOutput($sformatf("v%0d.clken", k), 32'(ram_clken), 32'(tbl[k].e.clken));
            checkOutput($sformatf("v%0d.st0", k), 32'(stall_cnt0), 32'(tbl[k].e.st0));
            checkOutput($sformatf("v%0d.st1", k), 32'(stall_cnt1), 32'(tbl[k].e.st1));
            if (tbl[k].e.cs) checkOutput($sformatf("v%0d.addr", k), 32'(ram_address), 32'(tbl[k].e.addr));
            if (tbl[k].e.rdv0) checkOutput($sformatf("v%0d.rdata0", k), m0_readdata, tbl[k].e.rdata);
            if (tbl[k].e.rdv1) checkOutput($sformatf("v%0d.rdata1", k), m1_readdata, tbl[k].e.rdata);
        end

        // Reset arriving the cycle after an accepted m0 read. The accept also
        // leaves m0 as last winner, so without reset m1 would win next.
        applyStimulus('{Y, N, 12'h0A5, 4'h0, 32'h0, N, N, 12'h0, 4'h0, 32'h0, N});
        #1;
        checkOutput("t6.accept_wait0", 32'(m0_waitrequest), 32'd0);
        applyStimulus(IDLE);
        reset_n = 1'b0;
        #1;
        checkOutput("t6.rdv0_dropped", 32'(m0_readdatavalid), 32'd0);
        checkOutput("t6.wait0_in_reset", 32'(m0_waitrequest), 32'd1);
        applyStimulus(IDLE);
        applyStimulus(IDLE);
        reset_n = 1'b1;
        #1;
        checkOutput("t6.rdv0_after", 32'(m0_readdatavalid), 32'd0);
        checkOutput("t6.st0", 32'(stall_cnt0), 32'd0);
        checkOutput("t6.st1", 32'(stall_cnt1), 32'd0);
        applyStimulus('{Y, N, 12'h001, 4'h0, 32'h0, Y, N, 12'h002, 4'h0, 32'h0, N});
        #1;
        checkOutput("t6.first_wait0", 32'(m0_waitrequest), 32'd0);
        checkOutput("t6.first_wait1", 32'(m1_waitrequest), 32'd1);

        // Ten cycles of continuous contention on both instances.
        applyStimulus(IDLE);
        reset_n = 1'b0;
        applyStimulus(IDLE);
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            applyStimulus('{Y, N, 12'(k), 4'h0, 32'h0, Y, N, 12'h200, 4'h0, 32'h0, N});
            #1;
            checkOutput($sformatf("t3.c%0d.wait1_fixed", k), 32'(m1_waitrequest_f), 32'd1);
            if (!m0_waitrequest_f) accepts++;
        end
        applyStimulus(IDLE);
        #1;
        checkOutput("t3.accepts0_fixed", 32'(accepts), 32'd10);
        checkOutput("t3.st1_fixed", 32'(stall_cnt1_f), 32'd10);
        checkOutput("t3.st0_fixed", 32'(stall_cnt0_f), 32'd0);
        checkOutput("t3.st0_rr", 32'(stall_cnt0), 32'd5);
        checkOutput("t3.st1_rr", 32'(stall_cnt1), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
